sdpram_clr_bypass: RTL and testbench

//  Single-clock simple-dual-port RAM with per-byte write enables and read-during-write forwarding.

---
 rtl/sdpram_clr_bypass_if.sv | 31 +++
 rtl/sdpram_clr_bypass.sv | 139 +++++++++++++
 tb/tb_sdpram_clr_bypass.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdpram_clr_bypass_if.sv
// Bus bundle for sdpram_clr_bypass: clear control, write port and read port.
// master drives requests; slave is the RAM.
interface sdpram_clr_bypass_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BYTE_SIZE  = 8
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / BYTE_SIZE;

    logic                  init_req;
    logic                  init_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_byte_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_oce;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output init_req, wr_en, wr_addr, wr_data, wr_byte_en, rd_en, rd_addr, rd_oce,
        input  init_busy, rd_data, rd_valid
    );

    modport slave (
        input  init_req, wr_en, wr_addr, wr_data, wr_byte_en, rd_en, rd_addr, rd_oce,
        output init_busy, rd_data, rd_valid
    );
endinterface

// File: rtl/sdpram_clr_bypass.sv
// Simple-dual-port RAM with byte enables, read-during-write forwarding, optional
// output register and a clear engine that fills the array with CLR_VAL.
module sdpram_clr_bypass #(
    parameter int unsigned           ADDR_WIDTH = 9,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           BYTE_SIZE  = 8,
    parameter int unsigned           OUTPUT_REG = 1,
    parameter int unsigned           BYPASS_EN  = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VAL    = '0
) (
    input  logic               clk,
    input  logic               rst,
    sdpram_clr_bypass_if.slave bus
);
    localparam int unsigned           BE_WIDTH  = DATA_WIDTH / BYTE_SIZE;
    localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] clr_addr_nx;
    logic                  busy_nx;
    logic                  clr_we_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_old_c;
    logic [DATA_WIDTH-1:0] rd_fwd_c;
    logic [DATA_WIDTH-1:0] d1;
    logic                  v1;

    // Clear engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_CLEAR;
            clr_addr      <= '0;
            bus.init_busy <= 1'b1;
        end else begin
            state         <= state_nx;
            clr_addr      <= clr_addr_nx;
            bus.init_busy <= busy_nx;
        end
    end

    // Clear engine next state: sweep every word once, then wait for init_req
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        clr_we_c    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we_c    = 1'b1;
                clr_addr_nx = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.init_req) begin
                    state_nx    = ST_CLEAR;
                    clr_addr_nx = '0;
                end
            end
            default: begin
                state_nx    = ST_CLEAR;
                clr_addr_nx = '0;
            end
        endcase
        busy_nx = (state_nx == ST_CLEAR);
    end

    // User traffic is locked out while the clear engine owns the array
    assign wr_acc_c = bus.wr_en & ~bus.init_busy;
    assign rd_acc_c = bus.rd_en & ~bus.init_busy;

    // Single write port shared by the clear engine and the user
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (wr_acc_c) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (bus.wr_byte_en[i]) begin
                    mem[bus.wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    assign rd_old_c = mem[bus.rd_addr];

    // Same-address write in the read cycle overrides the enabled lanes
    always_comb begin
        rd_fwd_c = rd_old_c;
        if ((BYPASS_EN != 0) && wr_acc_c && (bus.wr_addr == bus.rd_addr)) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (bus.wr_byte_en[i]) begin
                    rd_fwd_c[i*BYTE_SIZE +: BYTE_SIZE] = bus.wr_data[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    // Read stage 1; d1 keeps the last accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc_c;
            if (rd_acc_c) begin
                d1 <= rd_fwd_c;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bus.rd_data  <= '0;
                    bus.rd_valid <= 1'b0;
                end else if (bus.rd_oce) begin
                    bus.rd_data  <= d1;
                    bus.rd_valid <= v1;
                end
            end
        end else begin : g_noreg
            assign bus.rd_data  = d1;
            assign bus.rd_valid = v1;
        end
    endgenerate
endmodule

// File: tb/tb_sdpram_clr_bypass.sv
// Bench for sdpram_clr_bypass: two configurations driven by one stimulus stream,
// checked every cycle against a word-level model plus directed scenario checks.
module tb_sdpram_clr_bypass;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sdpram_clr_bypass_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BYTE_SIZE(8)) bus_a ();
    sdpram_clr_bypass_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8),  .BYTE_SIZE(8)) bus_b ();

    // a: 32-bit, registered output, forwarding on
    sdpram_clr_bypass #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BYTE_SIZE(8),
        .OUTPUT_REG(1), .BYPASS_EN(1), .CLR_VAL(32'hA5A5_A5A5)
    ) u_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    // b: 8-bit, unregistered output, forwarding off
    sdpram_clr_bypass #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(8), .BYTE_SIZE(8),
        .OUTPUT_REG(0), .BYPASS_EN(0), .CLR_VAL(8'hA5)
    ) u_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus shared by both instances
    logic        s_init_req;
    logic        s_wr_en;
    logic        s_rd_en;
    logic        s_oce;
    logic [3:0]  s_wr_addr;
    logic [3:0]  s_rd_addr;
    logic [31:0] s_wr_data;
    logic [3:0]  s_be;

    // reference model state, index 0 = a, 1 = b
    logic [31:0] m_mem   [2][DEPTH];
    int          m_busy  [2];
    logic [31:0] m_d1    [2];
    logic        m_v1    [2];
    logic [31:0] m_out_d [2];
    logic        m_out_v [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be, input int lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < lanes; i++) begin
            if (be[i]) r[i*8 +: 8] = data[i*8 +: 8];
        end
        return r;
    endfunction

    // Effect of one rising edge on the model, from the inputs presented before it
    task automatic model_edge(input int id);
        int          lanes;
        bit          oreg;
        bit          byp;
        bit          acc;
        logic [31:0] clr;
        logic [31:0] wnew;
        logic [31:0] rval;
        lanes = (id == 0) ? 4 : 1;
        oreg  = (id == 0);
        byp   = (id == 0);
        clr   = (id == 0) ? 32'hA5A5_A5A5 : 32'h0000_00A5;
        if (rst) begin
            m_busy[id]  = DEPTH;
            m_d1[id]    = '0;
            m_v1[id]    = 1'b0;
            m_out_d[id] = '0;
            m_out_v[id] = 1'b0;
            return;
        end
        acc  = (m_busy[id] == 0);
        wnew = merge(m_mem[id][s_wr_addr], s_wr_data, s_be, lanes);
        rval = (byp && acc && s_wr_en && (s_wr_addr == s_rd_addr)) ? wnew : m_mem[id][s_rd_addr];
        if (oreg && s_oce) begin
            m_out_d[id] = m_d1[id];
            m_out_v[id] = m_v1[id];
        end
        if (acc && s_rd_en) begin
            m_d1[id] = rval;
            m_v1[id] = 1'b1;
        end else begin
            m_v1[id] = 1'b0;
        end
        if (!oreg) begin
            m_out_d[id] = m_d1[id];
            m_out_v[id] = m_v1[id];
        end
        if (!acc) begin
            m_mem[id][DEPTH - m_busy[id]] = clr;
            m_busy[id]--;
        end else begin
            if (s_wr_en) m_mem[id][s_wr_addr] = wnew;
            if (s_init_req) m_busy[id] = DEPTH;
        end
    endtask

    task automatic drive();
        bus_a.init_req   = s_init_req;  bus_b.init_req   = s_init_req;
        bus_a.wr_en      = s_wr_en;     bus_b.wr_en      = s_wr_en;
        bus_a.wr_addr    = s_wr_addr;   bus_b.wr_addr    = s_wr_addr;
        bus_a.wr_data    = s_wr_data;   bus_b.wr_data    = s_wr_data[7:0];
        bus_a.wr_byte_en = s_be;        bus_b.wr_byte_en = s_be[0:0];
        bus_a.rd_en      = s_rd_en;     bus_b.rd_en      = s_rd_en;
        bus_a.rd_addr    = s_rd_addr;   bus_b.rd_addr    = s_rd_addr;
        bus_a.rd_oce     = s_oce;       bus_b.rd_oce     = s_oce;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("a_busy",  32'(bus_a.init_busy), 32'(m_busy[0] != 0));
        chk("a_valid", 32'(bus_a.rd_valid),  32'(m_out_v[0]));
        chk("a_data",  bus_a.rd_data,        m_out_d[0]);
        chk("b_busy",  32'(bus_b.init_busy), 32'(m_busy[1] != 0));
        chk("b_valid", 32'(bus_b.rd_valid),  32'(m_out_v[1]));
        chk("b_data",  32'(bus_b.rd_data),   m_out_d[1]);
    endtask

    task automatic idle();
        s_init_req = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_oce = 1'b1;
        s_wr_addr = '0; s_rd_addr = '0; s_wr_data = '0; s_be = '0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        s_wr_en = 1'b1; s_wr_addr = addr; s_wr_data = data; s_be = be;
        step();
        s_wr_en = 1'b0;
    endtask

    // Step until busy drops (bounded); noisy mode pushes traffic that must be dropped
    task automatic count_busy(input bit noisy, output int n);
        n = 0;
        do begin
            if (noisy) begin
                s_wr_en = 1'b1; s_wr_addr = 4'd2; s_wr_data = 32'hFFFF_FFFF; s_be = 4'hF;
                s_rd_en = 1'b1; s_rd_addr = 4'd2;
                s_init_req = (n == 3);
            end
            step();
            n++;
            if (noisy) begin
                chk("drop_valid_a", 32'(bus_a.rd_valid), 32'd0);
                chk("drop_valid_b", 32'(bus_b.rd_valid), 32'd0);
            end
        end while (bus_a.init_busy && n < 100);
        idle();
    endtask

    task automatic rd_check(input logic [3:0] addr, input logic [31:0] exp_a, input logic [7:0] exp_b,
                            input string tag);
        s_rd_en = 1'b1; s_rd_addr = addr;
        step();
        s_rd_en = 1'b0;
        chk({tag, "_b_valid"}, 32'(bus_b.rd_valid), 32'd1);
        chk({tag, "_b_data"},  32'(bus_b.rd_data),  32'(exp_b));
        chk({tag, "_a_lat"},   32'(bus_a.rd_valid), 32'd0);
        step();
        chk({tag, "_a_valid"}, 32'(bus_a.rd_valid), 32'd1);
        chk({tag, "_a_data"},  bus_a.rd_data,       exp_a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(bus_a.init_busy), 32'd1);
        rst = 1'b0;

        // T1: power-up clear then read every word
        count_busy(1'b0, n);
        chk("t1_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd_check(4'(i), 32'hA5A5_A5A5, 8'hA5, "t1");
        end

        // T2: byte-lane merge
        wr(4'd3, 32'h1122_3344, 4'hF);
        wr(4'd3, 32'hAABB_CCDD, 4'b0101);
        rd_check(4'd3, 32'h11BB_33DD, 8'hDD, "t2");

        // T3: same-cycle write/read of word 7
        wr(4'd7, 32'h0000_0012, 4'hF);
        s_wr_en = 1'b1; s_wr_addr = 4'd7; s_wr_data = 32'h0000_0034; s_be = 4'hF;
        rd_check(4'd7, 32'h0000_0034, 8'h12, "t3");
        s_wr_en = 1'b0;

        // T4: read lost behind rd_oce=0, then normal
        wr(4'd5, 32'h5A5A_0055, 4'hF);
        step();
        s_rd_en = 1'b1; s_rd_addr = 4'd5;
        step();
        s_rd_en = 1'b0; s_oce = 1'b0;
        step();
        chk("t4_hold_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("t4_hold_data",  bus_a.rd_data,       32'h0000_0034);
        step();
        chk("t4_hold_data2", bus_a.rd_data,       32'h0000_0034);
        s_oce = 1'b1;
        rd_check(4'd5, 32'h5A5A_0055, 8'h55, "t4");

        // T5/T6: reset mid-clear, init_req and traffic while busy are ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        chk("t5_rst_busy", 32'(bus_a.init_busy), 32'd1);
        rst = 1'b0;
        count_busy(1'b1, n);
        chk("t5_busy_cycles", 32'(n), 32'd16);
        rd_check(4'd2, 32'hA5A5_A5A5, 8'hA5, "t6_drop");

        // T6: re-clear from idle, including a write in the init_req cycle
        wr(4'd9, 32'h0000_005A, 4'hF);
        rd_check(4'd9, 32'h0000_005A, 8'h5A, "t6_wr");
        s_init_req = 1'b1;
        wr(4'd10, 32'h0000_005A, 4'hF);
        s_init_req = 1'b0;
        count_busy(1'b0, n);
        chk("t6_busy_cycles", 32'(n), 32'd16);
        rd_check(4'd9,  32'hA5A5_A5A5, 8'hA5, "t6_clr9");
        rd_check(4'd10, 32'hA5A5_A5A5, 8'hA5, "t6_clr10");

        // Random traffic with colliding addresses, stray resets and re-clears
        for (int k = 0; k < 1500; k++) begin
            rst        = ($urandom_range(0, 399) == 0);
            s_init_req = ($urandom_range(0, 63) == 0);
            s_wr_en    = ($urandom_range(0, 3) != 0);
            s_rd_en    = ($urandom_range(0, 3) != 0);
            s_oce      = ($urandom_range(0, 3) != 0);
            s_wr_addr  = 4'($urandom);
            s_rd_addr  = ($urandom_range(0, 2) == 0) ? s_wr_addr : 4'($urandom);
            s_wr_data  = $urandom;
            s_be       = 4'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        for (int k = 0; k < 20; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
